// File: rtl/rv_boot_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Stream layout: little-endian 16-bit word count, then 4 little-endian bytes per word.
package rv_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Byte-counter value of the final byte of a word.
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/rv_byte_packer.sv
// Little-endian 4-byte word assembler; word/word_valid register one cycle after the 4th byte.
// Never stalls: one byte per cycle accepted whenever byte_en is high; clr drops a partial word.
module rv_byte_packer
  import rv_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] acc;

  assign word_last = byte_en && (cnt == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      acc        <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= word_last && !clr;
      if (clr) begin
        cnt <= 2'd0;
        acc <= 24'd0;
      end else if (byte_en) begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd0:    acc[7:0]   <= byte_data;
          2'd1:    acc[15:8]  <= byte_data;
          2'd2:    acc[23:16] <= byte_data;
          default: word       <= {byte_data, acc};
        endcase
      end
    end
  end

endmodule

// File: rtl/rv_imem_loader.sv
// Fills instruction memory from a length-prefixed byte stream, holding the core in reset until done.
// Write strobe lands one cycle after the 4th byte of each word; the stream is never stalled.
module rv_imem_loader
  import rv_boot_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int TIMEOUT     = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              instr_wr_en,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [31:0]       instr_in,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LEN_W = 8 * LEN_BYTES;

  loader_state_t    state, state_nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] word_idx;
  logic [31:0]      idle_cnt;
  logic             hs;
  logic             timeout;
  logic             start_ok;
  logic             data_hs;
  logic             word_last;
  logic             last_word;

  assign byte_ready = (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_DATA);
  assign hs         = byte_valid && byte_ready;
  assign data_hs    = hs && (state == ST_DATA);
  assign timeout    = (idle_cnt == 32'(TIMEOUT - 1));
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign len_in     = {byte_data, len[7:0]};
  assign last_word  = (word_idx == len - LEN_W'(1));

  rv_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .byte_en    (data_hs),
    .byte_data  (byte_data),
    .word_last  (word_last),
    .word_valid (instr_wr_en),
    .word       (instr_in)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nxt = ST_LEN0;
      end
      ST_LEN0: begin
        if (hs)           state_nxt = ST_LEN1;
        else if (timeout) state_nxt = ST_ERR;
      end
      ST_LEN1: begin
        if (hs) begin
          if (len_in == '0)                              state_nxt = ST_DONE;
          else if (32'(len_in) > 32'(DEPTH_WORDS))       state_nxt = ST_ERR;
          else                                           state_nxt = ST_DATA;
        end else if (timeout) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (word_last && last_word) state_nxt = ST_FLUSH;
        end else if (timeout) begin
          state_nxt = ST_ERR;
        end
      end
      // One extra cycle so the final write strobe precedes the core release.
      ST_FLUSH: state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len        <= '0;
      word_idx   <= '0;
      idle_cnt   <= 32'd0;
      instr_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      busy       <= (state_nxt == ST_LEN0) || (state_nxt == ST_LEN1) ||
                    (state_nxt == ST_DATA) || (state_nxt == ST_FLUSH);
      done       <= (state_nxt == ST_DONE);
      err        <= (state_nxt == ST_ERR);
      core_rst_n <= (state_nxt == ST_DONE);

      if (start_ok) begin
        len      <= '0;
        word_idx <= '0;
        idle_cnt <= 32'd0;
      end else begin
        if (byte_ready) idle_cnt <= hs ? 32'd0 : idle_cnt + 32'd1;
        else            idle_cnt <= 32'd0;

        if (hs && (state == ST_LEN0)) len[7:0] <= byte_data;
        if (hs && (state == ST_LEN1)) len      <= len_in;

        if (word_last) begin
          instr_addr <= ADDR_W'({word_idx, 2'b00});
          word_idx   <= word_idx + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_imem_loader.sv
// Directed bench for rv_imem_loader: nominal, zero/over length, timeout, gapped stream, reset mid-load.
module tb_rv_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        instr_wr_en;
  logic [15:0] instr_addr;
  logic [31:0] instr_in;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  rv_imem_loader #(
    .ADDR_W      (16),
    .DEPTH_WORDS (1024),
    .TIMEOUT     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .instr_wr_en (instr_wr_en),
    .instr_addr  (instr_addr),
    .instr_in    (instr_in),
    .core_rst_n  (core_rst_n),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] wa[$];
  logic [31:0] wd[$];
  time         wr_t = 0;
  time         core_rise_t = 0;
  time         err_rise_t = 0;
  time         hs_t = 0;
  logic        prev_core = 1'b0;
  logic        prev_err = 1'b0;

  logic [7:0] nom_bytes[$]  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  logic [7:0] zero_bytes[$] = '{8'h00, 8'h00};
  logic [7:0] over_bytes[$] = '{8'h01, 8'h04};
  logic [7:0] tmo_bytes[$]  = '{8'h01, 8'h00, 8'hAA, 8'hBB};
  logic [7:0] new_bytes[$]  = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};

  always @(negedge clk) begin
    if (instr_wr_en) begin
      wa.push_back(instr_addr);
      wd.push_back(instr_in);
      wr_t = $time;
    end
    if (core_rst_n && !prev_core) core_rise_t = $time;
    if (err && !prev_err) err_rise_t = $time;
    prev_core = core_rst_n;
    prev_err  = err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    core_rise_t = 0;
    err_rise_t  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      check("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    hs_t = $time;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] bs[$], input bit gap);
    foreach (bs[i]) begin
      send_byte(bs[i]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_wr_en"},      {31'd0, instr_wr_en}, 32'd0);
    check({tag, "_addr"},       {16'd0, instr_addr}, 32'd0);
    check({tag, "_instr_in"},   instr_in, 32'd0);
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    check({tag, "_busy"},       {31'd0, busy}, 32'd0);
    check({tag, "_done"},       {31'd0, done}, 32'd0);
    check({tag, "_err"},        {31'd0, err}, 32'd0);
  endtask

  task automatic check_two_writes(input string tag, input logic [31:0] d0, input logic [31:0] d1);
    check({tag, "_nwrites"}, wa.size(), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_addr0"}, {16'd0, wa[0]}, 32'h0000_0000);
      check({tag, "_data0"}, wd[0], d0);
      check({tag, "_addr1"}, {16'd0, wa[1]}, 32'h0000_0004);
      check({tag, "_data1"}, wd[1], d1);
    end
    check({tag, "_core_rise"}, 32'(core_rise_t - wr_t), 32'd10);
    check({tag, "_done"},       {31'd0, done}, 32'd1);
    check({tag, "_err"},        {31'd0, err}, 32'd0);
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd1);
    check({tag, "_busy"},       {31'd0, busy}, 32'd0);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
  endtask

  initial begin
    idle(2);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal two-word load, back-to-back bytes
    clear_mon();
    pulse_start();
    check("nom_busy", {31'd0, busy}, 32'd1);
    check("nom_ready", {31'd0, byte_ready}, 32'd1);
    send_seq(nom_bytes, 1'b0);
    idle(3);
    check_two_writes("nom", 32'h0010_0513, 32'h0020_0593);

    // Zero length, starting from DONE: core goes back into reset at once
    clear_mon();
    pulse_start();
    check("zero_core_drop", {31'd0, core_rst_n}, 32'd0);
    check("zero_done_clr", {31'd0, done}, 32'd0);
    send_seq(zero_bytes, 1'b0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_core", {31'd0, core_rst_n}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    idle(2);
    check("zero_nwrites", wa.size(), 32'd0);

    // Over-length: 1025 words
    clear_mon();
    pulse_start();
    send_seq(over_bytes, 1'b0);
    check("over_err", {31'd0, err}, 32'd1);
    check("over_core", {31'd0, core_rst_n}, 32'd0);
    check("over_done", {31'd0, done}, 32'd0);
    check("over_ready", {31'd0, byte_ready}, 32'd0);
    idle(3);
    check("over_nwrites", wa.size(), 32'd0);
    check("over_err_hold", {31'd0, err}, 32'd1);

    // Timeout mid-word, restarting from ERR
    clear_mon();
    pulse_start();
    check("tmo_err_clr", {31'd0, err}, 32'd0);
    check("tmo_busy", {31'd0, busy}, 32'd1);
    send_seq(tmo_bytes, 1'b0);
    idle(12);
    check("tmo_delay", 32'(err_rise_t - hs_t), 32'd85);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_nwrites", wa.size(), 32'd0);
    check("tmo_core", {31'd0, core_rst_n}, 32'd0);

    // Gapped stream with a start pulse mid-load
    clear_mon();
    pulse_start();
    for (int i = 0; i < 4; i++) send_seq('{nom_bytes[i]}, 1'b1);
    pulse_start();
    check("gap_busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 4; i < 10; i++) send_seq('{nom_bytes[i]}, 1'b1);
    idle(3);
    check_two_writes("gap", 32'h0010_0513, 32'h0020_0593);

    // Reset after two data bytes, then a fresh load
    clear_mon();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(nom_bytes[i]);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    pulse_start();
    send_seq(new_bytes, 1'b0);
    idle(3);
    check_two_writes("reload", 32'hDEAD_BEEF, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_imem_loader.md
Name: rv_imem_loader

Overview:
- Boot-time controller that fills the core's instruction memory from a byte stream, then releases the core.
- It sits between an external byte source (UART/debug bridge) and the instruction memory write port (instr_wr_en / instr_in / addr).
- It holds the single-cycle core in reset for the whole load and releases it only after a complete, in-range image has been written.
- The stream format is a 16-bit little-endian word count followed by the instruction words, each sent as 4 little-endian bytes.

Parameters:
- ADDR_W, 16, width of the instruction-memory byte address.
- DEPTH_WORDS, 1024, capacity of the instruction memory in 32-bit words.
- TIMEOUT, 65535, number of idle cycles between accepted bytes that aborts a load; must be at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- start  in  1  single-cycle pulse that begins a load.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- instr_wr_en  out  1  instruction memory write strobe.
- instr_addr  out  ADDR_W  byte address of the write; always a multiple of 4.
- instr_in  out  32  instruction word to write.
- core_rst_n  out  1  active-low reset to the core.
- busy  out  1  a load is in progress.
- done  out  1  the last load completed successfully.
- err  out  1  the last load aborted.

Behaviour:
- Reset values: byte_ready=0, instr_wr_en=0, instr_addr=0, instr_in=0, core_rst_n=0, busy=0, done=0, err=0. FSM state is IDLE. All internal counters are 0.
- All outputs are registered, except byte_ready, which is decoded from the current state.
- A handshake occurs when byte_valid && byte_ready on a rising clk edge. byte_data is sampled only on a handshake.
- FSM states: IDLE, LEN0, LEN1, DATA, FLUSH, DONE, ERR.
- IDLE:
  - core_rst_n=0.
  - start moves the FSM to LEN0, sets busy=1, and clears done, err, the word counter and the byte counter.
- LEN0: byte_ready=1. A handshake latches len[7:0] and moves to LEN1.
- LEN1: byte_ready=1. A handshake latches len[15:8]. Then:
  - if len==0, go to DONE;
  - if len>DEPTH_WORDS, go to ERR;
  - otherwise go to DATA.
- DATA:
  - byte_ready=1.
  - A 2-bit byte counter places byte k into word bits [8k+7:8k].
  - The handshake that completes byte 3 registers, for the next cycle: instr_wr_en=1 for exactly one cycle, instr_in=the assembled word, instr_addr=word_idx*4. word_idx then increments.
  - The stream is never stalled; back-to-back bytes at one per cycle are supported.
  - When the completed word is word number len-1, go to FLUSH.
- FLUSH: lasts one cycle, so the final write pulse is issued. Then go to DONE.
- DONE:
  - busy=0, done=1, core_rst_n=1, byte_ready=0.
  - core_rst_n rises in the cycle after the last instr_wr_en pulse, never in the same cycle.
  - start returns the FSM to LEN0, drops core_rst_n to 0 on the next edge, and reloads.
- ERR:
  - busy=0, err=1, core_rst_n=0, byte_ready=0.
  - Writes already issued are not undone.
  - start restarts the load, exactly as from IDLE.
- Timeout:
  - An idle counter runs in LEN0, LEN1 and DATA.
  - It clears on every handshake and on entry to LEN0.
  - Reaching TIMEOUT-1 without a handshake moves the FSM to ERR on the next edge.
  - A handshake in that same cycle takes priority over the timeout.
- start while busy=1 is ignored.
- Bytes presented in IDLE, DONE or ERR are not accepted (byte_ready=0).
- instr_addr arithmetic is modulo 2^ADDR_W. word_idx never exceeds DEPTH_WORDS-1 because of the len check.
- rst_n low in any state, including mid-word, returns to the reset values on the same edge. A partially assembled word is discarded and never written.

Decomposition:
- Shared package rv_boot_pkg holds:
  - the typedef loader_state_t (enum of the 7 states);
  - the constant LEN_BYTES=2;
  - the constant BYTES_PER_WORD=4.
- Natural sub-module: rv_byte_packer, the 4-byte little-endian assembler with its byte counter and word_valid pulse.
- The FSM, counters and timeout stay in rv_imem_loader.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 02 00, 13 05 10 00, 93 05 20 00 at one byte per cycle.
  - Response: two writes, addr 0x0000 data 0x00100513, then addr 0x0004 data 0x00200593. core_rst_n rises the cycle after the second write; done=1, err=0.
- Zero length:
  - Stimulus: start, then bytes 00 00.
  - Response: no instr_wr_en; DONE in the cycle after the second byte; core_rst_n=1.
- Over-length:
  - Stimulus: start, then bytes 01 04 (len=1025) with DEPTH_WORDS=1024.
  - Response: ERR, err=1, core_rst_n stays 0, zero writes.
- Timeout mid-word:
  - Stimulus: TIMEOUT=8; start, 01 00, AA BB, then valid held low.
  - Response: ERR exactly 8 cycles after the BB handshake; no write.
- Gapped stream and ignored start:
  - Stimulus: byte_valid toggles every other cycle; start is pulsed mid-load.
  - Response: identical writes to the nominal load; the start pulse has no effect.
- Reset mid-load:
  - Stimulus: rst_n=0 after 2 data bytes, then a fresh nominal load.
  - Response: all outputs return to reset values; the first write of the new load is addr 0x0000 with the new data.
